// File: rtl/simon_pkg.sv
// Shared constants, state encoding and LFSR step rule for the Simon sequence path.
package simon_pkg;

    localparam logic [1:0]  COL_B     = 2'b00;
    localparam logic [1:0]  COL_G     = 2'b01;
    localparam logic [1:0]  COL_R     = 2'b10;
    localparam logic [1:0]  COL_Y     = 2'b11;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Galois right-shift step: feed the shifted-out bit back through the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// 16-bit Galois LFSR with seed load and explicit step enable (never free-running).
module simon_lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // A zero seed would lock the LFSR at zero, so it is swapped for the reset seed.
    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = (seed_i == 16'h0000) ? SEED : seed_i;
        else if (step_i)
            state_d = lfsr_next(state_q);
    end

    // State register, reset to the seed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= SEED;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/simon_seq_gen.sv
// Simon colour sequence generator: grows a random sequence one colour per
// extend and streams it out on a valid/ready handshake.
module simon_seq_gen
    import simon_pkg::*;
#(
    parameter int          MAX_LEN   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       seed_load,
    input  logic [15:0]                seed,
    input  logic                       clear,
    input  logic                       extend,
    input  logic                       start_play,
    input  logic                       color_ready,
    output logic                       color_valid,
    output logic [1:0]                 color,
    output logic                       last,
    output logic                       done,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       full,
    output logic                       busy
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [LW-1:0]   len_q,   len_d;
    logic [1:0]      mem_q [MAX_LEN];

    logic [15:0]     lfsr;
    logic            lfsr_load;
    logic            lfsr_adv;
    logic            mem_we;
    logic            is_full;
    logic            is_last;

    simon_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (lfsr_load),
        .seed_i  (seed),
        .step_i  (lfsr_adv),
        .state_o (lfsr)
    );

    assign is_full = (len_q == LW'(MAX_LEN));
    assign is_last = ({1'b0, idx_q} == (len_q - LW'(1)));

    // Next-state: IDLE arbitrates commands by priority; PLAY/DONE only honour clear.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    len_d = '0;
                end else if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (start_play) begin
                    idx_d   = '0;
                    state_d = (len_q != '0) ? PLAY : DONE;
                end else if (extend && !is_full) begin
                    mem_we   = 1'b1;
                    lfsr_adv = 1'b1;
                    len_d    = len_q + LW'(1);
                end
            end
            PLAY: begin
                if (clear) begin
                    len_d   = '0;
                    state_d = IDLE;
                end else if (color_ready) begin
                    if (is_last)
                        state_d = DONE;
                    else
                        idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (clear)
                    len_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Sequence storage; colour taken from the pre-step LFSR value. Not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[len_q[IW-1:0]] <= lfsr[1:0];
    end

    // Outputs come straight from registers, so they hold while stalled.
    assign color_valid = (state_q == PLAY);
    assign color       = color_valid ? mem_q[idx_q] : COL_B;
    assign last        = color_valid & is_last;
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign length      = len_q;
    assign full        = is_full;

endmodule

// File: tb/tb_simon_seq_gen.sv
module tb_simon_seq_gen;

    localparam int MAX_LEN = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        seed_load, clear, extend, start_play, color_ready;
    logic [15:0] seed;
    logic        color_valid, last, done, full, busy;
    logic [1:0]  color;
    logic [4:0]  length;

    int total = 0;
    int bad   = 0;

    // Reference model: the stored colours and the LFSR value.
    logic [1:0]  m_seq[$];
    logic [15:0] m_lfsr;

    simon_seq_gen #(.MAX_LEN(MAX_LEN), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .resetn(resetn), .seed_load(seed_load), .seed(seed),
        .clear(clear), .extend(extend), .start_play(start_play),
        .color_ready(color_ready), .color_valid(color_valid), .color(color),
        .last(last), .done(done), .length(length), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] x);
        if (x % 2 == 1) return (x / 2) ^ 16'hB400;
        return x / 2;
    endfunction

    task automatic quiet();
        clear = 0; seed_load = 0; extend = 0; start_play = 0; seed = '0;
    endtask

    // Called one cycle after start_play was sampled; walks the playback.
    task automatic play_check(input bit rnd, input int stall_at, input int stall_len, input bit noise);
        int i = 0;
        int n = m_seq.size();
        int stalled = 0;
        if (n == 0) begin
            chk("empty_done", done, 1);
            chk("empty_valid", color_valid, 0);
            tick();
            chk("empty_done_off", done, 0);
            chk("empty_valid_off", color_valid, 0);
            chk("empty_idle", busy, 0);
            return;
        end
        for (int cyc = 0; cyc < 400 && i < n; cyc++) begin
            if (rnd) color_ready = 1'($urandom_range(0, 1));
            else if (i == stall_at && stalled < stall_len) begin color_ready = 0; stalled++; end
            else color_ready = 1;
            if (noise) begin
                extend     = 1'($urandom_range(0, 1));
                start_play = 1'($urandom_range(0, 1));
                seed_load  = 1'($urandom_range(0, 1));
                seed       = 16'($urandom);
            end
            chk("play_valid", color_valid, 1);
            chk("play_color", color, m_seq[i]);
            chk("play_last", last, (i == n - 1));
            chk("play_done", done, 0);
            chk("play_len", length, n);
            tick();
            if (color_ready) i++;
        end
        quiet();
        color_ready = 1;
        if (i < n) chk("play_timeout", 0, 1);
        chk("end_done", done, 1);
        chk("end_valid", color_valid, 0);
        tick();
        chk("end_done_off", done, 0);
        chk("end_idle", busy, 0);
    endtask

    // One command cycle in IDLE; the model applies the priority rule.
    task automatic issue(input bit c, input bit sl, input logic [15:0] sv, input bit sp, input bit e,
                         input bit rnd, input int stall_at, input int stall_len, input bit noise);
        clear = c; seed_load = sl; seed = sv; start_play = sp; extend = e; color_ready = 1;
        tick();
        quiet();
        if (c) m_seq.delete();
        else if (sl) m_lfsr = (sv == 0) ? 16'hACE1 : sv;
        else if (sp) begin
            play_check(rnd, stall_at, stall_len, noise);
            return;
        end else if (e && m_seq.size() < MAX_LEN) begin
            m_seq.push_back(m_lfsr[1:0]);
            m_lfsr = m_step(m_lfsr);
        end
        chk("len", length, m_seq.size());
        chk("full", full, (m_seq.size() == MAX_LEN));
        chk("busy", busy, 0);
    endtask

    task automatic ext(); issue(0, 0, 0, 0, 1, 0, -1, 0, 0); endtask
    task automatic play(); issue(0, 0, 0, 1, 0, 0, -1, 0, 0); endtask

    initial begin
        resetn = 0; color_ready = 0; quiet();
        m_lfsr = 16'hACE1;
        #12;
        chk("rst_valid", color_valid, 0);
        chk("rst_color", color, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_len", length, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        resetn = 1;
        tick();

        // Five extends from reset, then play: expect 01,00,00,00,10.
        repeat (5) ext();
        begin
            logic [9:0] exp_cols = {2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
            for (int k = 0; k < 5; k++) chk("model_seq", m_seq[k], exp_cols[9-2*k -: 2]);
        end
        play();

        // Backpressure mid-stream on a 3-colour sequence.
        issue(1, 0, 0, 0, 0, 0, -1, 0, 0);
        repeat (3) ext();
        issue(0, 0, 0, 1, 0, 0, 1, 4, 0);

        // Fill to capacity; 17th extend is dropped.
        issue(1, 0, 0, 0, 0, 0, -1, 0, 0);
        repeat (17) ext();
        chk("full_len", length, 16);
        play();

        // clear beats extend; noisy commands during PLAY are ignored.
        issue(1, 0, 0, 0, 1, 0, -1, 0, 0);
        ext(); ext();
        issue(0, 0, 0, 1, 0, 1, -1, 0, 1);
        issue(1, 0, 0, 0, 0, 0, -1, 0, 0);
        play();

        // Seed load: zero substitutes the reset seed, 0002 yields colour 10.
        issue(0, 1, 16'h0000, 0, 0, 0, -1, 0, 0);
        ext();
        issue(0, 1, 16'h0002, 0, 0, 0, -1, 0, 0);
        ext();
        chk("seed_col0", m_seq[0], 2'b01);
        chk("seed_col1", m_seq[1], 2'b10);
        play();

        // Abort with clear mid-PLAY.
        repeat (2) ext();
        start_play = 1; tick(); start_play = 0;
        color_ready = 0;
        chk("abort_valid_pre", color_valid, 1);
        tick();
        clear = 1; tick(); clear = 0;
        m_seq.delete();
        chk("abort_busy", busy, 0);
        chk("abort_valid", color_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_len", length, 0);
        tick();
        chk("abort_no_done", done, 0);
        color_ready = 1;

        // Asynchronous reset mid-PLAY.
        repeat (3) ext();
        start_play = 1; tick(); start_play = 0;
        chk("arst_valid_pre", color_valid, 1);
        #2 resetn = 0;
        #1;
        chk("arst_valid", color_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_len", length, 0);
        #2 resetn = 1;
        tick();
        m_seq.delete();
        m_lfsr = 16'hACE1;
        chk("arst_len_after", length, 0);
        ext();
        play();

        // Random command mix, including simultaneous commands.
        for (int r = 0; r < 60; r++) begin
            bit c  = ($urandom_range(0, 9) == 0);
            bit sl = ($urandom_range(0, 7) == 0);
            bit sp = ($urandom_range(0, 4) == 0);
            bit e  = ($urandom_range(0, 2) != 0);
            logic [15:0] sv = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            issue(c, sl, sv, sp, e, 1, -1, 0, 1);
        end
        play();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
